// File: rtl/alu_seq_v2.sv
// Sequential ARM-style ALU: single-cycle data-processing ops plus an iterative
// shift-add MUL/MLA, with valid/ready handshakes and a registered CZVN flag set.
module alu_seq_v2 #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             s_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_we,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] mcand_reg, mplier_reg, acc_reg, acc_next;
  logic             mul_s_reg;
  logic [WIDTH-1:0] result_reg;
  logic             res_we_reg, out_valid_reg;
  logic [3:0]       flags_reg;

  logic             accept, is_mul, mul_done;
  logic [WIDTH-1:0] alu_x, alu_y, alu_res;
  logic [WIDTH:0]   alu_sum;
  logic             alu_cin, alu_arith, alu_known, alu_cmp, alu_v, alu_we, alu_upd;
  logic [3:0]       alu_flags;

  assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && ((op == 5'b10000) || (op == 5'b10001));
  assign mul_done = (state_reg == MUL) && (cnt_reg == CW'(WIDTH - 1));
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_mul) state_next = MUL;
      MUL:     if (mul_done)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every add/subtract is x + y + cin; subtraction feeds the inverted subtrahend.
  always_comb begin
    alu_x     = '0;
    alu_y     = '0;
    alu_cin   = 1'b0;
    alu_arith = 1'b0;
    alu_known = 1'b1;
    alu_res   = '0;
    case (op)
      5'b00000, 5'b01000: alu_res = a & b;
      5'b00001, 5'b01001: alu_res = a ^ b;
      5'b01100:           alu_res = a | b;
      5'b01101:           alu_res = a;
      5'b01110:           alu_res = b & ~a;
      5'b01111:           alu_res = ~a;
      5'b00010, 5'b01010: begin alu_x = b; alu_y = ~a; alu_cin = 1'b1;         alu_arith = 1'b1; end
      5'b00011:           begin alu_x = a; alu_y = ~b; alu_cin = 1'b1;         alu_arith = 1'b1; end
      5'b00100, 5'b01011: begin alu_x = a; alu_y = b;  alu_cin = 1'b0;         alu_arith = 1'b1; end
      5'b00101:           begin alu_x = a; alu_y = b;  alu_cin = flags_reg[3]; alu_arith = 1'b1; end
      5'b00110:           begin alu_x = b; alu_y = ~a; alu_cin = flags_reg[3]; alu_arith = 1'b1; end
      5'b00111:           begin alu_x = a; alu_y = ~b; alu_cin = flags_reg[3]; alu_arith = 1'b1; end
      default:            alu_known = 1'b0;
    endcase
    alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {{WIDTH{1'b0}}, alu_cin};
    if (alu_arith) alu_res = alu_sum[WIDTH-1:0];
    alu_v     = (alu_x[WIDTH-1] == alu_y[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_x[WIDTH-1]);
    alu_cmp   = (op[4:2] == 3'b010);
    alu_we    = alu_known && !alu_cmp;
    alu_upd   = alu_known && (s_bit || alu_cmp);
    alu_flags = {alu_arith ? alu_sum[WIDTH] : flags_reg[3],
                 (alu_res == '0),
                 alu_arith ? alu_v : flags_reg[1],
                 alu_res[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      res_we_reg    <= 1'b0;
      flags_reg     <= 4'b0000;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      mul_s_reg     <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand_reg  <= a;
          mplier_reg <= b;
          acc_reg    <= op[0] ? c : '0;
          cnt_reg    <= '0;
          mul_s_reg  <= s_bit;
        end else begin
          result_reg    <= alu_res;
          res_we_reg    <= alu_we;
          out_valid_reg <= 1'b1;
          if (alu_upd) flags_reg <= alu_flags;
        end
      end
      // The final iteration writes its sum straight to the result register.
      if (state_reg == MUL) begin
        acc_reg    <= acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
        if (mul_done) begin
          result_reg    <= acc_next;
          res_we_reg    <= 1'b1;
          out_valid_reg <= 1'b1;
          if (mul_s_reg)
            flags_reg <= {flags_reg[3], (acc_next == '0), flags_reg[1], acc_next[WIDTH-1]};
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign res_we    = res_we_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_seq_v2.sv
// Directed bench for alu_seq_v2: ALU ops, flags, multiply latency, stalls and reset.
module tb_alu_seq_v2;

  localparam int W = 32;

  logic         clk, rst_n, in_valid, in_ready, s_bit, out_valid, out_ready, res_we;
  logic [4:0]   op;
  logic [W-1:0] a, b, c, result;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] res;
    logic        we;
    logic [3:0]  fl;
  } vec_t;

  alu_seq_v2 #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c(c), .s_bit(s_bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_we(res_we), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] cv, input logic s);
    op = o; a = av; b = bv; c = cv; s_bit = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; c = '0; s_bit = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h expected 00000000", result); end
    checks++; if (res_we !== 1'b0) begin errors++; $display("FAIL rst_res_we: got %b expected 0", res_we); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b expected 0000", flags); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    $display("reset: out_valid %b flags %b in_ready %b", out_valid, flags, in_ready);
  endtask

  task automatic test_add;
    issue(5'b00100, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
    $display("ADD: result %h res_we %b flags %b", result, res_we, flags);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_result: got %h expected 00000000", result); end
    checks++; if (res_we !== 1'b1) begin errors++; $display("FAIL add_res_we: got %b expected 1", res_we); end
    checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL add_flags: got %b expected 1100", flags); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_sub_adc;
    issue(5'b00010, 32'h1, 32'h0, 32'h0, 1'b1);
    $display("SUB: result %h flags %b", result, flags);
    checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_result: got %h expected FFFFFFFF", result); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL sub_flags: got %b expected 0001", flags); end
    issue(5'b00101, 32'h0, 32'h0, 32'h0, 1'b1);
    $display("ADC: result %h flags %b", result, flags);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL adc_result: got %h expected 00000000", result); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL adc_flags: got %b expected 0100", flags); end
  endtask

  task automatic test_cmp;
    issue(5'b01010, 32'h5, 32'h5, 32'h0, 1'b0);
    $display("CMP: res_we %b flags %b", res_we, flags);
    checks++; if (res_we !== 1'b0) begin errors++; $display("FAIL cmp_res_we: got %b expected 0", res_we); end
    checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL cmp_flags: got %b expected 1100", flags); end
    issue(5'b00100, 32'h2, 32'h3, 32'h0, 1'b0);
    $display("ADD s0: result %h flags %b", result, flags);
    checks++; if (result !== 32'h5) begin errors++; $display("FAIL adds0_result: got %h expected 00000005", result); end
    checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL adds0_flags: got %b expected 1100", flags); end
  endtask

  task automatic test_ops;
    vec_t v [14];
    v = '{
      '{5'b00100, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 4'b0011}, // ADD overflow
      '{5'b00001, 32'hF0F0F0F0, 32'hFFFFFFFF, 1'b1, 32'h0F0F0F0F, 1'b1, 4'b0010}, // EOR keeps C,V
      '{5'b01000, 32'h0000000F, 32'h000000F0, 1'b0, 32'h00000000, 1'b0, 4'b0110}, // TST
      '{5'b00110, 32'h00000001, 32'h00000005, 1'b1, 32'h00000003, 1'b1, 4'b1000}, // SBC C=0
      '{5'b00011, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b1, 4'b1000}, // RSB
      '{5'b00111, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 4'b1000}, // RSC C=1
      '{5'b01110, 32'h0000000F, 32'h000000FF, 1'b0, 32'h000000F0, 1'b1, 4'b1000}, // BIC
      '{5'b01111, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b1001}, // MVN
      '{5'b01101, 32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 4'b1100}, // MOV
      '{5'b01100, 32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b1, 4'b1100}, // ORR
      '{5'b01001, 32'h00000001, 32'h80000000, 1'b0, 32'h80000001, 1'b0, 4'b1001}, // TEQ
      '{5'b01011, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 4'b1100}, // CMN
      '{5'b00101, 32'h00000001, 32'h00000002, 1'b0, 32'h00000004, 1'b1, 4'b1100}, // ADC C=1
      '{5'b10010, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 4'b1100}  // unknown
    };
    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 32'h0, v[i].s);
      $display("vec %0d op %b: result %h res_we %b flags %b", i, v[i].op, result, res_we, flags);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid: got %b expected 1", i, out_valid); end
      checks++; if (result !== v[i].res) begin errors++; $display("FAIL vec%0d_result: got %h expected %h", i, result, v[i].res); end
      checks++; if (res_we !== v[i].we) begin errors++; $display("FAIL vec%0d_res_we: got %b expected %b", i, res_we, v[i].we); end
      checks++; if (flags !== v[i].fl) begin errors++; $display("FAIL vec%0d_flags: got %b expected %b", i, flags, v[i].fl); end
    end
  endtask

  task automatic test_mul;
    int cycles, low;
    issue(5'b10000, 32'h3, 32'h5, 32'h0, 1'b0);
    cycles = 0; low = 0;
    if (in_ready === 1'b0) low++;
    while (out_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (out_valid !== 1'b1 && in_ready === 1'b0) low++;
    end
    $display("MUL: result %h after %0d cycles, in_ready low %0d", result, cycles, low);
    checks++; if (cycles !== 32) begin errors++; $display("FAIL mul_latency: got %0d expected 32", cycles); end
    checks++; if (low !== 32) begin errors++; $display("FAIL mul_in_ready_low: got %0d expected 32", low); end
    checks++; if (result !== 32'hF) begin errors++; $display("FAIL mul_result: got %h expected 0000000F", result); end
    checks++; if (res_we !== 1'b1) begin errors++; $display("FAIL mul_res_we: got %b expected 1", res_we); end
    issue(5'b10001, 32'hFFFFFFFF, 32'h2, 32'h3, 1'b1);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    $display("MLA: result %h flags %b after %0d cycles", result, flags, cycles);
    checks++; if (cycles !== 32) begin errors++; $display("FAIL mla_latency: got %0d expected 32", cycles); end
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL mla_result: got %h expected 00000001", result); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL mla_flags: got %b expected 1000", flags); end
  endtask

  task automatic test_back_to_back;
    issue(5'b00100, 32'h1, 32'h1, 32'h0, 1'b1);
    out_ready = 1'b0;
    op = 5'b00010; a = 32'h1; b = 32'h9; c = 32'h0; s_bit = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      $display("stall %0d: out_valid %b result %h flags %b in_ready %b", i, out_valid, result, flags, in_ready);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid: got %b expected 1", i, out_valid); end
      checks++; if (result !== 32'h2) begin errors++; $display("FAIL stall%0d_result: got %h expected 00000002", i, result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL stall%0d_flags: got %b expected 0000", i, flags); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready: got %b expected 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("b2b SUB: out_valid %b result %h flags %b", out_valid, result, flags);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'h8) begin errors++; $display("FAIL b2b_result: got %h expected 00000008", result); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL b2b_flags: got %b expected 1000", flags); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mul;
    int seen;
    issue(5'b10000, 32'h3, 32'h5, 32'h0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("reset in MUL: out_valid %b flags %b in_ready %b", out_valid, flags, in_ready);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmul_valid: got %b expected 0", out_valid); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rmul_flags: got %b expected 0000", flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmul_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmul_no_result: got %0d valid cycles expected 0", seen); end
    issue(5'b00100, 32'h2, 32'h2, 32'h0, 1'b1);
    $display("ADD after reset: result %h flags %b", result, flags);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL radd_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'h4) begin errors++; $display("FAIL radd_result: got %h expected 00000004", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL radd_flags: got %b expected 0000", flags); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_adc();
    test_cmp();
    test_ops();
    test_mul();
    test_back_to_back();
    test_reset_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_v2.md
ALU_SEQ_V2 -- requirements
Module: alu_seq_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width in bits, legal range 8..64.
REQ-002 SHALL have parameter MUL_EN, default 1: 1 enables MUL/MLA; 0 makes them unknown ops.
REQ-003 SHALL have one clock, clk (input, 1): all state changes on its rising edge.
REQ-004 SHALL have rst_n (input, 1): asynchronous, active-low reset.
REQ-005 SHALL have in_valid (input, 1): operation request.
REQ-006 SHALL have in_ready (output, 1): block can accept a request.
REQ-007 SHALL have op (input, 5): opcode; 00000..01111 are the ARM data-processing encodings, 10000 is MUL, 10001 is MLA.
REQ-008 SHALL have a (input, WIDTH): shifter operand.
REQ-009 SHALL have b (input, WIDTH): Rn.
REQ-010 SHALL have c (input, WIDTH): MLA accumulate operand.
REQ-011 SHALL have s_bit (input, 1): update the flag register.
REQ-012 SHALL have out_valid (output, 1): result available.
REQ-013 SHALL have out_ready (input, 1): consumer takes the result.
REQ-014 SHALL have result (output, WIDTH): Rd value.
REQ-015 SHALL have res_we (output, 1): result is to be written to Rd.
REQ-016 SHALL have flags (output, 4): registered flags, bit 3 = C, bit 2 = Z, bit 1 = V, bit 0 = N.

Function
REQ-017 SHALL accept a request on the rising edge where in_valid && in_ready, capturing op, a, b, c and s_bit.
REQ-018 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-019 SHALL use a state machine with states IDLE and MUL.
REQ-020 IDLE: a non-multiply accept SHALL produce a registered result with out_valid high on the next edge (latency 1).
REQ-021 IDLE: a MUL/MLA accept SHALL go to MUL.
REQ-022 MUL SHALL run a shift-add iteration for WIDTH cycles.
REQ-023 On leaving MUL, the block SHALL return to IDLE with out_valid high, giving latency WIDTH+1 from accept.
REQ-024 out_valid, result, res_we and flags SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on an edge with out_ready unless a new accept occurs on the same edge, which SHALL back-to-back reload it.
REQ-026 SHALL compute:
 - AND a&b; EOR a^b; ORR a|b; BIC b&~a; MOV a; MVN ~a
 - SUB b-a; RSB a-b; ADD a+b
 - ADC a+b+C; SBC b-a-!C; RSC a-b-!C
 - MUL lower WIDTH bits of a*b; MLA lower WIDTH bits of a*b+c
REQ-027 All arithmetic SHALL be modulo 2^WIDTH.
REQ-028 The C input to ADC/SBC/RSC SHALL be the flag register value at accept time.
REQ-029 res_we SHALL be 0 for TST, TEQ, CMP, CMN and for unknown op, and 1 otherwise.
REQ-030 TST/TEQ/CMP/CMN SHALL compute as AND, EOR, SUB and ADD respectively.
REQ-031 TST/TEQ/CMP/CMN SHALL always update flags regardless of s_bit.
REQ-032 Flags SHALL update only when the result becomes valid and (s_bit or compare op); otherwise they SHALL stay unchanged.
REQ-033 N = result MSB and Z = (result == 0) for all flag-updating ops.
REQ-034 Additions SHALL set C to the carry out of bit WIDTH-1.
REQ-035 Subtractions SHALL set C = NOT borrow (b-a with b>=a unsigned gives C=1).
REQ-036 V SHALL be signed overflow of the performed add or subtract.
REQ-037 Logical ops, MOV, MVN, MUL and MLA SHALL leave C and V unchanged.
REQ-038 Unknown op SHALL complete in 1 cycle with result 0, res_we 0 and flags unchanged.
REQ-039 in_valid SHALL be ignored while in_ready is low; no request is queued.

Reset
REQ-040 When rst_n is low, SHALL asynchronously force state IDLE, out_valid 0, result 0, res_we 0, flags 0000 and multiply registers 0.
REQ-041 Reset during MUL SHALL abandon the operation with no output produced.
REQ-042 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Verification
REQ-043 ADD, a=FFFFFFFF, b=00000001, s_bit=1 -> one cycle later: result 00000000, res_we 1, flags C=1 Z=1 V=0 N=0.
REQ-044 SUB, a=1, b=0, s_bit=1 -> result FFFFFFFF, flags C=0 Z=0 V=0 N=1; then ADC, a=0, b=0 -> result 00000000 (C was 0).
REQ-045 CMP, a=5, b=5, s_bit=0 -> res_we 0, flags Z=1 C=1; a following ADD with s_bit=0 -> flags unchanged.
REQ-046 MUL, a=3, b=5 -> in_ready low for 32 cycles, out_valid on cycle 33 with result 0000000F; MLA, a=FFFFFFFF, b=2, c=3 -> 00000001.
REQ-047 out_ready held low 4 cycles after a result -> result and flags stable, in_ready 0; out_ready high with a new request waiting -> back-to-back accept.
REQ-048 rst_n pulsed low at cycle 10 of a MUL -> out_valid 0 and flags 0000 immediately; no result emitted; next ADD completes normally.
